carregador_matriz: RTL and testbench

Sequential loader that sits directly upstream of the matrix operation units (oposicao_matriz and its siblings). It receives matrix elements one byte per beat over a valid/ready stream and assembles them into the packed 5x5 signed 8-bit matrix bus (200 bits) consumed by those units. Active dimension is 2x2..5x5, and unused positions are zero-filled. The block presents the completed matrix with a valid/ready handshake and holds it stable until the consumer accepts it.

---
 rtl/carregador_matriz_pkg.sv | 17 +
 rtl/carregador_matriz.sv | 106 ++++++++++
 tb/tb_carregador_matriz.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_matriz_pkg.sv
// Shared widths, state encoding and dimension limits for the matrix loader
// and the matrix operation units fed by it.
package carregador_matriz_pkg;

    localparam int DATA_W  = 8;
    localparam int N_MAX   = 5;
    localparam int MAT_W   = N_MAX * N_MAX * DATA_W;
    localparam int TAM_MIN = 2;
    localparam int TAM_MAX = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/carregador_matriz.sv
// carregador_matriz: streams signed bytes into a packed 5x5 matrix bus.
// Ports: clk, reset (sync, high), start/tamanho begin a load of a
//   tamanho x tamanho matrix; in_valid/in_data/in_ready element stream
//   (row-major); matrix_out/out_valid/out_ready completed matrix
//   handshake; erro flags an illegal dimension on start.
module carregador_matriz
    import carregador_matriz_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        tamanho,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matrix_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              erro
);

    state_t     state;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] dim;
    logic [4:0] pos;
    logic [7:0] lsb;
    logic       tam_ok;
    logic       last_col;
    logic       last_row;

    // Position of the element being written in the 5x5 bus, regardless
    // of the active dimension, so unused positions are never touched.
    assign pos = 5'(row) * 5'(N_MAX) + 5'(col);
    assign lsb = 8'(pos) * 8'(DATA_W);

    assign tam_ok   = (tamanho >= 3'(TAM_MIN)) && (tamanho <= 3'(TAM_MAX));
    assign last_col = (col == dim - 3'd1);
    assign last_row = (row == dim - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            dim        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            erro       <= 1'b0;
            matrix_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    if (start) begin
                        if (tam_ok) begin
                            dim        <= tamanho;
                            matrix_out <= '0;
                            erro       <= 1'b0;
                            row        <= '0;
                            col        <= '0;
                            in_ready   <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            erro <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        matrix_out[lsb +: DATA_W] <= in_data;
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                // Counters return to 0 so they never
                                // exceed dim-1 while the matrix waits.
                                row       <= '0;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= FULL;
                            end else begin
                                row <= row + 3'd1;
                            end
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                FULL: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed testbench for carregador_matriz.
// Drives element streams and compares the packed matrix to local models.
module tb_carregador_matriz;
    import carregador_matriz_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        tamanho;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [MAT_W-1:0]  matrix_out;
    logic              out_valid;
    logic              out_ready;
    logic              erro;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [MAT_W-1:0] exp_m;
    int               rdy;

    carregador_matriz dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tamanho    (tamanho),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .matrix_out (matrix_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [MAT_W-1:0] got,
                         input logic [MAT_W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] t);
        start   = 1'b1;
        tamanho = t;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        tamanho   = 3'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_erro", erro, 0);
        check("rst_matrix", matrix_out, 0);
        reset = 1'b0;
        tick();

        // 5x5 load of 1..25, one element per cycle
        do_start(3'd5);
        check("t1_ready_after_start", in_ready, 1);
        rdy = 0;
        for (int k = 0; k < 25; k++) begin
            if (in_ready) rdy++;
            check("t1_valid_early", out_valid, 0);
            in_valid = 1'b1;
            in_data  = 8'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        exp_m = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                exp_m[(i*N_MAX+j)*DATA_W +: DATA_W] = 8'(i*5 + j + 1);
        check("t1_ready_cycles", rdy, 25);
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready_full", in_ready, 0);
        check("t1_matrix", matrix_out, exp_m);
        check("t1_elem00", matrix_out[7:0], 8'd1);
        check("t1_elem44", matrix_out[199:192], 8'd25);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_valid_drop", out_valid, 0);
        check("t1_matrix_kept", matrix_out, exp_m);

        // 3x3 load of -1..-9 with in_valid gaps
        do_start(3'd3);
        check("t2_cleared", matrix_out, 0);
        for (int k = 0; k < 9; k++) begin
            int g;
            g = $urandom_range(0, 2);
            for (int n = 0; n < g; n++) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                check("t2_ready_gap", in_ready, 1);
                check("t2_valid_gap", out_valid, 0);
                tick();
            end
            check("t2_valid_early", out_valid, 0);
            in_valid = 1'b1;
            in_data  = 8'(-(k + 1));
            tick();
        end
        in_valid = 1'b0;
        exp_m = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp_m[(i*N_MAX+j)*DATA_W +: DATA_W] = 8'(-(i*3 + j + 1));
        check("t2_out_valid", out_valid, 1);
        check("t2_matrix", matrix_out, exp_m);
        check("t2_elem00", matrix_out[7:0], 8'hFF);
        check("t2_elem02", matrix_out[23:16], 8'hFD);
        check("t2_elem22", matrix_out[103:96], 8'hF7);
        check("t2_col3_zero", matrix_out[31:24], 8'h00);

        // Hold in FULL with start/in_valid toggling
        tamanho = 3'd4;
        for (int k = 0; k < 20; k++) begin
            start    = k[0];
            in_valid = ~k[0];
            in_data  = 8'(k);
            tick();
            check("t3_hold_matrix", matrix_out, exp_m);
            check("t3_hold_ready", in_ready, 0);
            check("t3_hold_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("t3_idle_valid", out_valid, 0);
        check("t3_idle_ready", in_ready, 0);
        tick();
        check("t3_start_ignored", in_ready, 0);
        check("t3_matrix_kept", matrix_out, exp_m);

        // Illegal dimensions, then a legal start
        do_start(3'd1);
        check("t4_erro_1", erro, 1);
        check("t4_ready_1", in_ready, 0);
        do_start(3'd6);
        check("t4_erro_6", erro, 1);
        check("t4_ready_6", in_ready, 0);
        check("t4_matrix_kept", matrix_out, exp_m);
        do_start(3'd2);
        check("t4_erro_clr", erro, 0);
        check("t4_load", in_ready, 1);
        check("t4_cleared", matrix_out, 0);

        // Extreme values at 2x2, stored verbatim
        in_valid = 1'b1;
        in_data = 8'h80; tick();
        in_data = 8'h7F; tick();
        in_data = 8'h00; tick();
        check("t5_valid_early", out_valid, 0);
        in_data = 8'hFF; tick();
        in_valid = 1'b0;
        exp_m = '0;
        exp_m[7:0]   = 8'h80;
        exp_m[15:8]  = 8'h7F;
        exp_m[47:40] = 8'h00;
        exp_m[55:48] = 8'hFF;
        check("t5_out_valid", out_valid, 1);
        check("t5_matrix", matrix_out, exp_m);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a 4x4 load
        do_start(3'd4);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 + k);
            tick();
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_erro", erro, 0);
        check("t6_rst_matrix", matrix_out, 0);
        do_start(3'd4);
        for (int k = 0; k < 16; k++) begin
            check("t6_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + k);
            tick();
        end
        in_valid = 1'b0;
        exp_m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_m[(i*N_MAX+j)*DATA_W +: DATA_W] = 8'(8'h40 + i*4 + j);
        check("t6_out_valid", out_valid, 1);
        check("t6_matrix", matrix_out, exp_m);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
